// File: rtl/mdu_unit.sv
// ---------------------------------------------------------------------------
// mdu_unit -- E-stage multiply/divide unit.
//
// Sits beside the E-stage ALU and consumes the same forwarded operands.
// Executes mult/multu/div/divu with a fixed, parameterised busy period,
// owns the architectural HI/LO registers and serves mfhi/mflo/mthi/mtlo.
//
// The full 64-bit product or quotient/remainder pair is computed in the
// issue cycle and parked in pending HI/LO registers. A down-counter then
// models the fixed latency; HI/LO are only committed when the counter
// reaches its terminal count. This keeps the architectural timing
// independent of how the arithmetic is actually implemented.
//
// Ports:
//   clk           in   1   clock, rising edge
//   reset         in   1   synchronous reset, active low
//   E_MDU_A       in  32   operand A (forwarded rs)
//   E_MDU_B       in  32   operand B (forwarded rt)
//   E_MDU_MDUOp   in   4   0 none, 1 mult, 2 multu, 3 div, 4 divu,
//                          5 mfhi, 6 mflo, 7 mthi, 8 mtlo, others none
//   E_MDU_Start   out  1   combinational, high for op 1..4
//   E_MDU_Busy    out  1   registered, high while an operation is in flight
//   E_MDU_Result  out 32   combinational, HI for mfhi, LO for mflo, else 0
//
// Parameters:
//   MULT_CYCLES   busy period of mult/multu (must be >= 1)
//   DIV_CYCLES    busy period of div/divu   (must be >= 1)
// ---------------------------------------------------------------------------
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] E_MDU_A,
    input  logic [31:0] E_MDU_B,
    input  logic [3:0]  E_MDU_MDUOp,
    output logic        E_MDU_Start,
    output logic        E_MDU_Busy,
    output logic [31:0] E_MDU_Result
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic [31:0]      r_pend_hi;
    logic [31:0]      r_pend_lo;
    logic             r_pend_wr;     // pending result may be committed

    // -----------------------------------------------------------------------
    // Op decode
    // -----------------------------------------------------------------------
    logic w_is_mult;
    logic w_is_div;
    logic w_is_signed;
    logic w_start;
    logic w_busy;
    logic w_issue;
    logic w_last;

    assign w_is_mult   = (E_MDU_MDUOp == OP_MULT) || (E_MDU_MDUOp == OP_MULTU);
    assign w_is_div    = (E_MDU_MDUOp == OP_DIV)  || (E_MDU_MDUOp == OP_DIVU);
    assign w_is_signed = (E_MDU_MDUOp == OP_MULT) || (E_MDU_MDUOp == OP_DIV);
    assign w_start     = w_is_mult || w_is_div;
    assign w_busy      = (r_cnt != '0);
    // A start that arrives while busy is dropped entirely.
    assign w_issue     = w_start && !w_busy;
    assign w_last      = (r_cnt == CNT_W'(1));

    // -----------------------------------------------------------------------
    // Multiplier
    // The low 64 bits of a 64x64 product are the same for signed and
    // unsigned interpretations, so one unsigned multiplier serves both once
    // the operands are sign- or zero-extended to 64 bits.
    // -----------------------------------------------------------------------
    logic [63:0] w_mul_a;
    logic [63:0] w_mul_b;
    logic [63:0] w_prod;

    assign w_mul_a = {{32{w_is_signed & E_MDU_A[31]}}, E_MDU_A};
    assign w_mul_b = {{32{w_is_signed & E_MDU_B[31]}}, E_MDU_B};
    assign w_prod  = w_mul_a * w_mul_b;

    // -----------------------------------------------------------------------
    // Divider
    // Signed division is done on magnitudes and the signs re-applied, so the
    // 0x80000000 / -1 case falls out naturally (magnitude 0x80000000 still
    // fits in 32 unsigned bits and negating it wraps back to 0x80000000).
    // The divisor is forced to 1 on divide-by-zero only to keep the
    // arithmetic defined; that result is never committed.
    // -----------------------------------------------------------------------
    logic        w_a_neg;
    logic        w_b_neg;
    logic        w_div_zero;
    logic [31:0] w_ua;
    logic [31:0] w_ub_raw;
    logic [31:0] w_ub;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    assign w_a_neg    = w_is_signed & E_MDU_A[31];
    assign w_b_neg    = w_is_signed & E_MDU_B[31];
    assign w_div_zero = (E_MDU_B == 32'd0);
    assign w_ua       = w_a_neg ? (32'd0 - E_MDU_A) : E_MDU_A;
    assign w_ub_raw   = w_b_neg ? (32'd0 - E_MDU_B) : E_MDU_B;
    assign w_ub       = w_div_zero ? 32'd1 : w_ub_raw;
    assign w_uq       = w_ua / w_ub;
    assign w_ur       = w_ua % w_ub;
    // Quotient truncates toward zero; remainder follows the dividend's sign.
    assign w_quot     = (w_a_neg ^ w_b_neg) ? (32'd0 - w_uq) : w_uq;
    assign w_rem      = w_a_neg ? (32'd0 - w_ur) : w_ur;

    // -----------------------------------------------------------------------
    // Result selection for the pending registers
    // -----------------------------------------------------------------------
    logic [31:0] w_new_hi;
    logic [31:0] w_new_lo;

    always_comb begin
        w_new_hi = w_prod[63:32];
        w_new_lo = w_prod[31:0];
        if (w_is_div) begin
            w_new_hi = w_rem;
            w_new_lo = w_quot;
        end
    end

    // -----------------------------------------------------------------------
    // Latency counter and pending result
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_pend_wr <= 1'b0;
        end else if (w_issue) begin
            r_cnt     <= w_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            r_pend_hi <= w_new_hi;
            r_pend_lo <= w_new_lo;
            r_pend_wr <= !(w_is_div && w_div_zero);
        end else if (w_busy) begin
            r_cnt     <= r_cnt - CNT_W'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Architectural HI/LO
    // Commit on the terminal-count edge; moves only land while idle.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (w_busy) begin
            if (w_last && r_pend_wr) begin
                r_hi <= r_pend_hi;
                r_lo <= r_pend_lo;
            end
        end else begin
            if (E_MDU_MDUOp == OP_MTHI) begin
                r_hi <= E_MDU_A;
            end
            if (E_MDU_MDUOp == OP_MTLO) begin
                r_lo <= E_MDU_A;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    always_comb begin
        E_MDU_Result = 32'd0;
        case (E_MDU_MDUOp)
            OP_MFHI: E_MDU_Result = r_hi;
            OP_MFLO: E_MDU_Result = r_lo;
            default: E_MDU_Result = 32'd0;
        endcase
    end

    assign E_MDU_Start = w_start;
    assign E_MDU_Busy  = w_busy;

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- E-stage multiply/divide unit. Sits beside the E-stage ALU and takes the same forwarded operands (rs in A, rt in B).
- Executes mult/multu/div/divu with fixed multi-cycle latency and owns the HI/LO registers.
- Serves mfhi/mflo/mthi/mtlo.
- Exports Start/Busy so the D-stage hazard unit can stall MDU-class instructions.

Parameters:
- MULT_CYCLES, 5, cycles Busy stays high for mult/multu.
- DIV_CYCLES, 10, cycles Busy stays high for div/divu.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- E_MDU_A  input  32  operand A (forwarded rs).
- E_MDU_B  input  32  operand B (forwarded rt).
- E_MDU_MDUOp  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, others none.
- E_MDU_Start  output  1  combinational; 1 when MDUOp is 1..4.
- E_MDU_Busy  output  1  registered; 1 while an operation is in flight.
- E_MDU_Result  output  32  combinational; HI when op=5, LO when op=6, else 0.

Behaviour:
- Reset: when reset=0 at a rising edge, HI, LO, pending HI/LO and counter go to 0, so Busy=0.
  - Reset mid-operation aborts it; pending results are discarded.
- Issue:
  - A rising edge where Start=1 and Busy=0 loads the counter with MULT_CYCLES or DIV_CYCLES.
  - The same edge latches the full result into pending HI/LO, computed from A/B as sampled at that edge.
- Busy = (counter != 0).
  - Busy rises the cycle after the issue edge and stays high exactly N cycles.
  - While counter>0, each edge decrements it.
  - On the edge where the counter goes 1->0, HI/LO take the pending values.
  - New HI/LO are visible in the first cycle with Busy=0.
- mult: {HI,LO} = signed(A)*signed(B), 64-bit.
- multu: {HI,LO} = unsigned(A)*unsigned(B), 64-bit.
- div: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - A=0x80000000, B=0xFFFFFFFF: LO=0x80000000, HI=0.
- divu: LO = A/B, HI = A%B, unsigned.
- Divide by zero (B=0, div or divu):
  - Busy still runs DIV_CYCLES.
  - HI and LO keep their prior values at completion.
- mthi / mtlo:
  - When Busy=0, HI<=A or LO<=A at that edge, with no busy period.
  - When Busy=1 they are ignored.
- Start while Busy: ignored, no effect on counter or pending values.
  - The hazard unit never allows this; the bench flags it with an assertion.
- mfhi / mflo: combinational read of current HI/LO. The hazard unit stalls them while Start|Busy.
- Operand changes while Busy have no effect.
- Op codes 0 and 9-15 have no effect.

Test Plan:
- Reset: hold reset=0 for 2 cycles, then release -> Busy=0, mfhi and mflo both read 0.
- Signed multiply: mult with A=0xFFFFFFFE (-2), B=3 -> Busy high exactly 5 cycles; afterwards HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- Unsigned multiply: multu with A=0xFFFFFFFF, B=2 -> after 5 cycles HI=1, LO=0xFFFFFFFE.
- Signed divide: div with A=0xFFFFFFF9 (-7), B=2 -> Busy high 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Divide boundary cases:
  - divu A=7, B=0 with prior HI=0x11, LO=0x22 -> after 10 cycles HI=0x11, LO=0x22.
  - div A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- Ignored writes and mid-operation reset:
  - mthi A=0x1234 while Busy -> HI unchanged; mtlo A=0x55 while idle -> mflo returns 0x55 next cycle.
  - reset=0 during cycle 3 of a div -> Busy=0 and HI=LO=0 after that edge.
